// File: rtl/i2c_multibus_monitor.sv
`default_nettype none
// ============================================================================
// i2c_multibus_monitor : passive N-bus I2C monitor with a merged event FIFO
// Revision 1.0 - initial release
// ============================================================================
module i2c_multibus_monitor #(
    parameter int NUM_BUSES  = 16,
    parameter int FILTER_LEN = 3,
    parameter int FIFO_DEPTH = 16,
    parameter int STRETCH_W  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NUM_BUSES-1:0] scl_i,
    input  logic [NUM_BUSES-1:0] sda_i,
    input  logic [NUM_BUSES-1:0] enable_i,
    output logic                 evt_valid_o,
    input  logic                 evt_ready_i,
    output logic [3:0]           evt_bus_o,
    output logic [2:0]           evt_type_o,
    output logic [7:0]           evt_data_o,
    output logic                 evt_ack_o,
    output logic [STRETCH_W-1:0] evt_stretch_o,
    output logic [NUM_BUSES-1:0] busy_o,
    output logic                 overflow_o,
    input  logic                 overflow_clr_i
);

    localparam int BW = (NUM_BUSES > 1) ? $clog2(NUM_BUSES) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [2:0] EV_START  = 3'd0;
    localparam logic [2:0] EV_RSTART = 3'd1;
    localparam logic [2:0] EV_BYTE   = 3'd2;
    localparam logic [2:0] EV_STOP   = 3'd3;
    localparam logic [2:0] EV_ERROR  = 3'd4;

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_ACTIVE = 1'b1} state_t;

    typedef struct packed {
        logic [3:0]           bus;
        logic [2:0]           typ;
        logic [7:0]           data;
        logic                 ack;
        logic [STRETCH_W-1:0] stretch;
    } evt_t;

    evt_t                 w_hold [NUM_BUSES];
    logic [NUM_BUSES-1:0] w_hold_valid;
    logic [NUM_BUSES-1:0] w_grant_oh;
    logic [NUM_BUSES-1:0] w_drop;
    logic                 w_grant_valid;
    logic [BW-1:0]        w_grant_idx;
    logic [BW-1:0]        w_idx;
    logic [BW-1:0]        r_last;
    logic                 w_can_push;
    logic                 r_overflow;

    generate
        for (genvar i = 0; i < NUM_BUSES; i++) begin : g_bus
            logic [1:0] w_raw;
            logic [1:0] r_s1, r_s2, r_f, r_p;
            logic [3:0] r_fcnt [2];
            logic       w_start, w_stop, w_rise;

            state_t               r_state, w_state_nxt;
            logic [3:0]           r_bitcnt, w_bitcnt_nxt;
            logic [7:0]           r_shift, w_shift_nxt;
            logic [STRETCH_W-1:0] r_cnt, w_cnt_nxt, r_max, w_max_nxt, w_max_rise;
            logic                 w_ev_v;
            evt_t                 w_ev;
            logic                 r_hold_v;
            evt_t                 r_hold_l;

            assign w_raw = {sda_i[i], scl_i[i]};

            // Bit 0 is SCL, bit 1 is SDA; filtered lines move only after FILTER_LEN agreeing samples
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    r_s1      <= '1;
                    r_s2      <= '1;
                    r_f       <= '1;
                    r_p       <= '1;
                    r_fcnt[0] <= '0;
                    r_fcnt[1] <= '0;
                end else begin
                    r_s1 <= w_raw;
                    r_s2 <= r_s1;
                    r_p  <= r_f;
                    for (int k = 0; k < 2; k++) begin
                        if (r_s2[k] != r_f[k]) begin
                            if (r_fcnt[k] == 4'(FILTER_LEN - 1)) begin
                                r_f[k]    <= r_s2[k];
                                r_fcnt[k] <= '0;
                            end else begin
                                r_fcnt[k] <= r_fcnt[k] + 4'd1;
                            end
                        end else begin
                            r_fcnt[k] <= '0;
                        end
                    end
                end
            end

            // SCL high in both samples excludes simultaneous SCL/SDA changes
            assign w_start = r_p[0] & r_f[0] &  r_p[1] & ~r_f[1];
            assign w_stop  = r_p[0] & r_f[0] & ~r_p[1] &  r_f[1];
            assign w_rise  = ~r_p[0] & r_f[0];

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    r_state  <= S_IDLE;
                    r_bitcnt <= '0;
                    r_shift  <= '0;
                    r_cnt    <= '0;
                    r_max    <= '0;
                end else begin
                    r_state  <= w_state_nxt;
                    r_bitcnt <= w_bitcnt_nxt;
                    r_shift  <= w_shift_nxt;
                    r_cnt    <= w_cnt_nxt;
                    r_max    <= w_max_nxt;
                end
            end

            always_comb begin
                w_state_nxt  = r_state;
                w_bitcnt_nxt = r_bitcnt;
                w_shift_nxt  = r_shift;
                w_cnt_nxt    = r_cnt;
                w_max_nxt    = r_max;
                w_ev_v       = 1'b0;
                w_ev         = '0;
                w_ev.bus     = 4'(i);
                w_max_rise   = (r_cnt > r_max) ? r_cnt : r_max;
                if (!enable_i[i]) begin
                    w_state_nxt  = S_IDLE;
                    w_bitcnt_nxt = '0;
                    w_shift_nxt  = '0;
                    w_cnt_nxt    = '0;
                    w_max_nxt    = '0;
                end else begin
                    case (r_state)
                        S_IDLE: begin
                            if (w_start) begin
                                w_state_nxt  = S_ACTIVE;
                                w_bitcnt_nxt = '0;
                                w_shift_nxt  = '0;
                                w_cnt_nxt    = '0;
                                w_max_nxt    = '0;
                                w_ev_v       = 1'b1;
                                w_ev.typ     = EV_START;
                            end
                        end
                        S_ACTIVE: begin
                            if (w_start) begin
                                w_ev_v       = 1'b1;
                                w_ev.typ     = (r_bitcnt == 4'd0) ? EV_RSTART : EV_ERROR;
                                w_bitcnt_nxt = '0;
                                w_shift_nxt  = '0;
                                w_cnt_nxt    = '0;
                                w_max_nxt    = '0;
                            end else if (w_stop) begin
                                w_ev_v       = 1'b1;
                                w_ev.typ     = (r_bitcnt == 4'd0) ? EV_STOP : EV_ERROR;
                                w_state_nxt  = S_IDLE;
                                w_bitcnt_nxt = '0;
                                w_shift_nxt  = '0;
                                w_cnt_nxt    = '0;
                                w_max_nxt    = '0;
                            end else if (w_rise) begin
                                w_cnt_nxt = '0;
                                if (r_bitcnt == 4'd8) begin
                                    w_ev_v       = 1'b1;
                                    w_ev.typ     = EV_BYTE;
                                    w_ev.data    = r_shift;
                                    w_ev.ack     = ~r_f[1];
                                    w_ev.stretch = w_max_rise;
                                    w_bitcnt_nxt = '0;
                                    w_shift_nxt  = '0;
                                    w_max_nxt    = '0;
                                end else begin
                                    w_shift_nxt  = {r_shift[6:0], r_f[1]};
                                    w_bitcnt_nxt = r_bitcnt + 4'd1;
                                    w_max_nxt    = w_max_rise;
                                end
                            end else if (!r_f[0] && (r_cnt != '1)) begin
                                w_cnt_nxt = r_cnt + STRETCH_W'(1);
                            end
                        end
                        default: w_state_nxt = S_IDLE;
                    endcase
                end
            end

            // A slot being granted this cycle is free for a new event at the same edge
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    r_hold_v <= 1'b0;
                    r_hold_l <= '0;
                end else if (!enable_i[i]) begin
                    r_hold_v <= 1'b0;
                    r_hold_l <= '0;
                end else if (w_ev_v && (!r_hold_v || w_grant_oh[i])) begin
                    r_hold_v <= 1'b1;
                    r_hold_l <= w_ev;
                end else if (w_grant_oh[i]) begin
                    r_hold_v <= 1'b0;
                end
            end

            assign w_drop[i]       = w_ev_v & r_hold_v & ~w_grant_oh[i];
            assign w_hold[i]       = r_hold_l;
            assign w_hold_valid[i] = r_hold_v;
            assign busy_o[i]       = (r_state == S_ACTIVE);
        end
    endgenerate

    // Round-robin search starting just after the last granted bus
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_idx   = '0;
        w_grant_oh    = '0;
        w_idx         = '0;
        for (int k = 1; k <= NUM_BUSES; k++) begin
            w_idx = BW'((int'(r_last) + k) % NUM_BUSES);
            if (!w_grant_valid && w_hold_valid[w_idx] && w_can_push) begin
                w_grant_valid     = 1'b1;
                w_grant_idx       = w_idx;
                w_grant_oh[w_idx] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_last <= BW'(NUM_BUSES - 1);
        end else if (w_grant_valid) begin
            r_last <= w_grant_idx;
        end
    end

    evt_t          r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr, r_rd;
    logic [AW:0]   r_count;
    logic          w_full, w_pop, w_push;
    evt_t          w_head;

    assign w_full     = (r_count == (AW+1)'(FIFO_DEPTH));
    assign w_pop      = evt_valid_o & evt_ready_i;
    assign w_can_push = ~w_full | w_pop;
    assign w_push     = w_grant_valid;

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr] <= w_hold[w_grant_idx];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + AW'(1);
            if (w_pop)  r_rd <= r_rd + AW'(1);
            if (w_push && !w_pop)      r_count <= r_count + (AW+1)'(1);
            else if (!w_push && w_pop) r_count <= r_count - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_overflow <= 1'b0;
        end else if (|w_drop) begin
            r_overflow <= 1'b1;
        end else if (overflow_clr_i) begin
            r_overflow <= 1'b0;
        end
    end

    assign w_head        = r_mem[r_rd];
    assign evt_valid_o   = (r_count != '0);
    assign evt_bus_o     = evt_valid_o ? w_head.bus     : '0;
    assign evt_type_o    = evt_valid_o ? w_head.typ     : '0;
    assign evt_data_o    = evt_valid_o ? w_head.data    : '0;
    assign evt_ack_o     = evt_valid_o ? w_head.ack     : 1'b0;
    assign evt_stretch_o = evt_valid_o ? w_head.stretch : '0;
    assign overflow_o    = r_overflow;

endmodule
`default_nettype wire
